ins_prefetch: RTL and testbench

INS_PREFETCH -- requirements
Module: ins_prefetch

---
 rtl/music_pkg.sv | 35 +++
 rtl/ins_fifo.sv | 59 +++++
 rtl/ins_prefetch.sv | 122 ++++++++++++
 tb/tb_ins_prefetch.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared opcode constants, instruction class and fetch FSM types
package music_pkg;

   localparam logic [3:0] OP_END = 4'b0000;
   localparam logic [3:0] OP_BPM = 4'b0001;

   typedef enum logic [1:0] {
      CLS_NOTE,
      CLS_END,
      CLS_BPM,
      CLS_ILLEGAL
   } ins_class_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_CAPTURE,
      ST_STOPPED
   } fetch_state_t;

   function automatic ins_class_t classify(input logic [15:0] word);
      ins_class_t c;
      if (word[15])
         c = CLS_NOTE;
      else if (word[15:12] == OP_END)
         c = CLS_END;
      else if (word[15:12] == OP_BPM)
         c = CLS_BPM;
      else
         c = CLS_ILLEGAL;
      return c;
   endfunction

endpackage

// File: rtl/ins_fifo.sv
// rtl/ins_fifo.sv - synchronous instruction FIFO with flush, count and full/empty flags
module ins_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         // Simultaneous push and pop leaves the occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (do_push && !flush)
         mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ins_prefetch.sv
// rtl/ins_prefetch.sv - program-word prefetcher from wait-state SRAM into an instruction FIFO
// Optional macro INS_PREFETCH_ILLEGAL_SKIP_EN: drop ILLEGAL words and expose ILLEGAL_CNT.
module ins_prefetch
   import music_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int SRAM_WAIT  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [ADDR_W-1:0] START_ADDR,
   output logic [ADDR_W-1:0] SRAM_A,
   input  logic [15:0]       SRAM_D,
   output logic [15:0]       INS,
   output logic              INS_VALID,
   input  logic              INS_READY,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] PC
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
   ,
   output logic [15:0]       ILLEGAL_CNT
`endif
);
   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [2:0] WAIT_LOAD = (SRAM_WAIT >= 2) ? 3'(SRAM_WAIT - 2) : 3'd0;

   fetch_state_t  state;
   logic [2:0]    wait_cnt;
   ins_class_t    cls;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [15:0]   fifo_head;
   logic [CW-1:0] fifo_count;
   logic          end_xfer;

   assign cls       = classify(SRAM_D);
   assign fifo_pop  = !fifo_empty && INS_READY;
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
   assign fifo_push = (state == ST_CAPTURE) && !START && (cls != CLS_ILLEGAL);
`else
   assign fifo_push = (state == ST_CAPTURE) && !START;
`endif
   // Nothing is pushed after END, so in STOPPED the last entry leaving is the END word.
   assign end_xfer  = (state == ST_STOPPED) && fifo_pop && (fifo_count == CW'(1));
   assign INS_VALID = !fifo_empty;
   assign INS       = fifo_empty ? 16'h0000 : fifo_head;

   ins_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .flush     (START),
      .push      (fifo_push),
      .push_data (SRAM_D),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
         PC       <= '0;
         SRAM_A   <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
         ILLEGAL_CNT <= '0;
`endif
      end else if (START) begin
         // Restart from any state: the in-flight read is abandoned and its data never pushed.
         state <= ST_ISSUE;
         PC    <= START_ADDR;
         BUSY  <= 1'b1;
         DONE  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_ISSUE: begin
               if (!fifo_full) begin
                  SRAM_A   <= PC;
                  wait_cnt <= WAIT_LOAD;
                  state    <= (SRAM_WAIT == 1) ? ST_CAPTURE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 3'd0)
                  state <= ST_CAPTURE;
               else
                  wait_cnt <= wait_cnt - 1'b1;
            end
            ST_CAPTURE: begin
               PC <= PC + 1'b1;
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
               if (cls == CLS_ILLEGAL && ILLEGAL_CNT != 16'hFFFF)
                  ILLEGAL_CNT <= ILLEGAL_CNT + 1'b1;
`endif
               state <= (cls == CLS_END) ? ST_STOPPED : ST_ISSUE;
            end
            ST_STOPPED: begin
               if (end_xfer) begin
                  state <= ST_IDLE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ins_prefetch.sv
// tb/tb_ins_prefetch.sv - self-checking bench for ins_prefetch against a program-stream reference model
module tb_ins_prefetch;
   localparam int ADDR_W     = 18;
   localparam int SRAM_WAIT  = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int MEM_WORDS  = 1 << ADDR_W;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              START = 1'b0;
   logic              INS_READY = 1'b0;
   logic [ADDR_W-1:0] START_ADDR = '0;
   logic [ADDR_W-1:0] SRAM_A;
   logic [ADDR_W-1:0] PC;
   logic [15:0]       SRAM_D;
   logic [15:0]       INS;
   logic              INS_VALID;
   logic              BUSY;
   logic              DONE;
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
   logic [15:0]       ILLEGAL_CNT;
`endif

   logic [15:0]       mem [MEM_WORDS];
   logic [15:0]       got [$];
   logic [15:0]       exp_q [$];
   logic [ADDR_W-1:0] exp_pc;
   int                exp_ill;
   int                vectors = 0;
   int                errors = 0;
   bit                rand_ready = 1'b0;

   assign SRAM_D = mem[SRAM_A];

   always #10 CLK = ~CLK;

   ins_prefetch #(
      .ADDR_W     (ADDR_W),
      .SRAM_WAIT  (SRAM_WAIT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .START      (START),
      .START_ADDR (START_ADDR),
      .SRAM_A     (SRAM_A),
      .SRAM_D     (SRAM_D),
      .INS        (INS),
      .INS_VALID  (INS_VALID),
      .INS_READY  (INS_READY),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .PC         (PC)
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
      ,
      .ILLEGAL_CNT (ILLEGAL_CNT)
`endif
   );

   // Executor side: record every word that transfers (a START cycle flushes instead).
   always @(negedge CLK) begin
      if (RST_N && INS_VALID && INS_READY && !START)
         got.push_back(INS);
   end

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         if (rand_ready)
            INS_READY = 1'($urandom_range(0, 1));
      end
   end

   // Reference: walk memory from the start address until an END word, by opcode nibble.
   task automatic build_model(input logic [ADDR_W-1:0] a0);
      logic [ADDR_W-1:0] a;
      logic [15:0]       w;
      logic [3:0]        op;
      exp_q.delete();
      exp_ill = 0;
      a = a0;
      for (int n = 0; n < 4096; n++) begin
         w  = mem[a];
         op = w[15:12];
         a  = a + 1'b1;
         if (op >= 4'd2 && op <= 4'd7) begin
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
            exp_ill++;
            continue;
`endif
         end
         exp_q.push_back(w);
         if (op == 4'd0)
            break;
      end
      exp_pc = a;
   endtask

   task automatic start_prog(input logic [ADDR_W-1:0] a0);
      @(posedge CLK);
      #1;
      START_ADDR = a0;
      START      = 1'b1;
      got.delete();
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (DONE) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge CLK);
      vectors++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL rst_ins_valid got %b want 0", INS_VALID); end
      vectors++; if (INS !== 16'h0000) begin errors++; $display("FAIL rst_ins got %h want 0000", INS); end
      vectors++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
      vectors++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", DONE); end
      vectors++; if (PC !== '0) begin errors++; $display("FAIL rst_pc got %h want 0", PC); end
      vectors++; if (SRAM_A !== '0) begin errors++; $display("FAIL rst_sram_a got %h want 0", SRAM_A); end
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      vectors++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", BUSY); end
   endtask

   task automatic test_basic;
      int lat;
      bit ok;
      mem[0] = 16'h8F21; mem[1] = 16'h1060; mem[2] = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b1;
      build_model(0);
      start_prog(0);
      lat = 0;
      while (lat < 20) begin
         @(negedge CLK);
         if (INS_VALID) break;
         lat++;
      end
      vectors++; if (lat !== 1 + SRAM_WAIT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, 1 + SRAM_WAIT); end
      wait_done(200, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got DONE=%b want 1", DONE); end
      vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d got %h want %h", i, got[i], exp_q[i]); end
      end
      vectors++; if (PC !== 18'd3) begin errors++; $display("FAIL basic_pc got %h want 3", PC); end
      vectors++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", BUSY); end
      vectors++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL basic_drained got %b want 0", INS_VALID); end
   endtask

   task automatic test_backpressure;
      bit ok;
      for (int i = 0; i < 10; i++) mem[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      mem[10] = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b0;
      build_model(0);
      start_prog(0);
      repeat (30) @(negedge CLK);
      vectors++; if (PC !== 18'd4) begin errors++; $display("FAIL bp_pc got %h want 4", PC); end
      vectors++; if (SRAM_A !== 18'd3) begin errors++; $display("FAIL bp_sram_a got %h want 3", SRAM_A); end
      vectors++; if (INS !== mem[0] || INS_VALID !== 1'b1) begin errors++; $display("FAIL bp_head got %h/%b want %h/1", INS, INS_VALID, mem[0]); end
      repeat (7) @(negedge CLK);
      vectors++; if (SRAM_A !== 18'd3 || PC !== 18'd4) begin errors++; $display("FAIL bp_stable got %h/%h want 3/4", SRAM_A, PC); end
      @(posedge CLK);
      #1;
      INS_READY = 1'b1;
      wait_done(400, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL bp_done_timeout got DONE=%b want 1", DONE); end
      vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, got[i], exp_q[i]); end
      end
      vectors++; if (PC !== exp_pc) begin errors++; $display("FAIL bp_end_pc got %h want %h", PC, exp_pc); end
   endtask

   task automatic test_wrap;
      bit ok;
      mem[18'h3FFFF] = 16'hC123;
      mem[0]         = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b1;
      build_model(18'h3FFFF);
      start_prog(18'h3FFFF);
      wait_done(200, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout got DONE=%b want 1", DONE); end
      vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL wrap_len got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_word%0d got %h want %h", i, got[i], exp_q[i]); end
      end
      vectors++; if (PC !== exp_pc) begin errors++; $display("FAIL wrap_pc got %h want %h", PC, exp_pc); end
      vectors++; if (SRAM_A !== '0) begin errors++; $display("FAIL wrap_sram_a got %h want 0", SRAM_A); end
   endtask

   task automatic test_restart;
      bit ok;
      for (int i = 0; i < 7; i++) mem[i] = 16'h9000 | 16'(i);
      mem[7] = 16'h0000;
      mem[18'h100] = 16'h1078; mem[18'h101] = 16'hA5A5; mem[18'h102] = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b0;
      start_prog(0);
      repeat (6) @(posedge CLK);
      build_model(18'h100);
      start_prog(18'h100);
      @(negedge CLK);
      vectors++; if (INS_VALID !== 1'b0) begin errors++; $display("FAIL rs_flush got %b want 0", INS_VALID); end
      vectors++; if (DONE !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL rs_flags got %b/%b want 0/1", DONE, BUSY); end
      vectors++; if (PC !== 18'h100) begin errors++; $display("FAIL rs_pc got %h want 100", PC); end
      @(posedge CLK);
      #1;
      INS_READY = 1'b1;
      wait_done(300, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL rs_done_timeout got DONE=%b want 1", DONE); end
      vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rs_len got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rs_word%0d got %h want %h", i, got[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_capture;
      for (int i = 0; i < 8; i++) mem[18'h20 + i] = 16'hB000 | 16'(i);
      mem[18'h28] = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b0;
      start_prog(18'h20);
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      vectors++; if (INS_VALID !== 1'b1 || BUSY !== 1'b1) begin errors++; $display("FAIL mr_pre got %b/%b want 1/1", INS_VALID, BUSY); end
      RST_N = 1'b0;
      #1;
      vectors++; if (INS_VALID !== 1'b0 || INS !== 16'h0000) begin errors++; $display("FAIL mr_ins got %b/%h want 0/0000", INS_VALID, INS); end
      vectors++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL mr_flags got %b/%b want 0/0", BUSY, DONE); end
      vectors++; if (PC !== '0 || SRAM_A !== '0) begin errors++; $display("FAIL mr_addr got %h/%h want 0/0", PC, SRAM_A); end
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (8) @(negedge CLK);
      vectors++; if (INS_VALID !== 1'b0 || BUSY !== 1'b0 || PC !== '0) begin errors++; $display("FAIL mr_no_resume got %b/%b/%h want 0/0/0", INS_VALID, BUSY, PC); end
   endtask

   task automatic test_illegal;
      bit ok;
      mem[0] = 16'h8F21; mem[1] = 16'h2ABC; mem[2] = 16'h1060; mem[3] = 16'h0000;
      rand_ready = 1'b0;
      INS_READY  = 1'b1;
      build_model(0);
      start_prog(0);
      wait_done(200, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL ill_done_timeout got DONE=%b want 1", DONE); end
      vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL ill_len got %0d want %0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got.size()) begin
         vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL ill_word%0d got %h want %h", i, got[i], exp_q[i]); end
      end
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
      vectors++; if (ILLEGAL_CNT !== 16'd1) begin errors++; $display("FAIL ill_cnt got %0d want 1", ILLEGAL_CNT); end
      if (got.size() > 1) begin
         vectors++; if (got[1] !== 16'h1060) begin errors++; $display("FAIL ill_second got %h want 1060", got[1]); end
      end
`else
      if (got.size() > 1) begin
         vectors++; if (got[1] !== 16'h2ABC) begin errors++; $display("FAIL ill_second got %h want 2abc", got[1]); end
      end
`endif
      vectors++; if (PC !== 18'd4) begin errors++; $display("FAIL ill_pc got %h want 4", PC); end
   endtask

   task automatic test_random;
      bit                ok;
      int                len;
      logic [ADDR_W-1:0] a0;
      logic [ADDR_W-1:0] a;
      logic [3:0]        op;
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
      int                ill_before;
`endif
      for (int it = 0; it < 8; it++) begin
         a0  = ADDR_W'($urandom_range(0, MEM_WORDS - 1));
         len = $urandom_range(1, 12);
         a   = a0;
         for (int i = 0; i < len; i++) begin
            case ($urandom_range(0, 2))
               0:       op = 4'(8 + $urandom_range(0, 7));
               1:       op = 4'd1;
               default: op = 4'($urandom_range(2, 7));
            endcase
            mem[a] = {op, 12'($urandom)};
            a = a + 1'b1;
         end
         mem[a] = {4'd0, 12'($urandom)};
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
         ill_before = int'(ILLEGAL_CNT);
`endif
         build_model(a0);
         rand_ready = 1'b1;
         start_prog(a0);
         wait_done(1500, ok);
         rand_ready = 1'b0;
         vectors++; if (!ok) begin errors++; $display("FAIL rnd%0d_done_timeout got DONE=%b want 1", it, DONE); end
         vectors++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_len got %0d want %0d", it, got.size(), exp_q.size()); end
         foreach (exp_q[i]) if (i < got.size()) begin
            vectors++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", it, i, got[i], exp_q[i]); end
         end
         vectors++; if (PC !== exp_pc) begin errors++; $display("FAIL rnd%0d_pc got %h want %h", it, PC, exp_pc); end
`ifdef INS_PREFETCH_ILLEGAL_SKIP_EN
         vectors++; if (int'(ILLEGAL_CNT) - ill_before != exp_ill) begin errors++; $display("FAIL rnd%0d_ill_cnt got %0d want %0d", it, int'(ILLEGAL_CNT) - ill_before, exp_ill); end
`endif
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_wrap;
      test_restart;
      test_reset_mid_capture;
      test_illegal;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
